// File: rtl/exec_unit_pipe.sv
// Tomasulo execution unit: accepts one dispatched op at a time, runs it for
// a per-op latency, queues completed results in a small FIFO and presents the
// FIFO head to the CDB arbiter until granted.
module exec_unit_pipe #(
  parameter int DATA_W    = 8,
  parameter int TAG_W     = 3,
  parameter int REG_W     = 4,
  parameter int LAT_ADD   = 2,
  parameter int LAT_MUL   = 4,
  parameter int LAT_DIV   = 6,
  parameter int RES_DEPTH = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [TAG_W-1:0]  rob_ind,
  input  logic [REG_W-1:0]  rd,
  input  logic              flush,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_rob,
  output logic [REG_W-1:0]  cdb_rd,
  output logic              cdb_exc,
  output logic              busy
);

  localparam int LAT_MAX = (LAT_DIV > LAT_MUL) ? ((LAT_DIV > LAT_ADD) ? LAT_DIV : LAT_ADD)
                                               : ((LAT_MUL > LAT_ADD) ? LAT_MUL : LAT_ADD);
  localparam int LCNT_W  = $clog2(LAT_MAX + 1);
  localparam int PTR_W   = $clog2(RES_DEPTH);

  localparam logic [LCNT_W-1:0] LAT_ONE  = LCNT_W'(1);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(RES_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_MUL = 4'b0010;
  localparam logic [3:0] F_DIV = 4'b0011;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q;
  logic [LCNT_W-1:0]   lat_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W:0]      count_q;

  logic [3:0]          func_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [REG_W-1:0]    rd_q;

  // Result entries carry the exception flag in the MSB above the data.
  logic [DATA_W:0]     res_mem [RES_DEPTH];
  logic [TAG_W-1:0]    rob_mem [RES_DEPTH];
  logic [REG_W-1:0]    rd_mem  [RES_DEPTH];

  logic                accept;
  logic                push;
  logic                pop;
  logic                fifo_nonempty;

  // Cycles an op spends in BUSY; undefined encodings finish after one cycle.
  function automatic logic [LCNT_W-1:0] op_latency(input logic [3:0] f);
    case (f)
      F_ADD, F_SUB: op_latency = LCNT_W'(LAT_ADD);
      F_MUL:        op_latency = LCNT_W'(LAT_MUL);
      F_DIV:        op_latency = LCNT_W'(LAT_DIV);
      default:      op_latency = LAT_ONE;
    endcase
  endfunction

  // Unsigned wrap-around arithmetic; returns {exc, data}.
  function automatic logic [DATA_W:0] alu_exec(input logic [3:0] f,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (f)
      F_ADD:   alu_exec = {1'b0, a + b};
      F_SUB:   alu_exec = {1'b0, a - b};
      F_MUL:   alu_exec = {1'b0, a * b};
      F_DIV:   alu_exec = (b == '0) ? {1'b1, {DATA_W{1'b1}}} : {1'b0, a / b};
      default: alu_exec = {1'b1, {DATA_W{1'b0}}};
    endcase
  endfunction

  assign fifo_nonempty = (count_q != '0);
  // in_ready is forced low while reset is asserted even though state reads IDLE.
  assign in_ready      = rst_n & (state_q == IDLE) & (count_q < FULL_CNT) & ~flush;
  assign accept        = in_valid & in_ready;
  assign push          = (state_q == BUSY) & (lat_q == LAT_ONE) & ~flush;
  assign pop           = cdb_grant & fifo_nonempty & ~flush;

  // Control: FSM, latency counter and FIFO pointers; flush clears like reset.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            lat_q   <= op_latency(func);
          end
        end
        BUSY: begin
          lat_q <= lat_q - LAT_ONE;
          if (lat_q == LAT_ONE) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Datapath: capture the dispatched op and write the finished result.
  always_ff @(posedge clk1) begin
    if (accept) begin
      func_q <= func;
      a_q    <= rs1_data;
      b_q    <= rs2_data;
      tag_q  <= rob_ind;
      rd_q   <= rd;
    end
    if (push) begin
      res_mem[wr_ptr_q] <= alu_exec(func_q, a_q, b_q);
      rob_mem[wr_ptr_q] <= tag_q;
      rd_mem[wr_ptr_q]  <= rd_q;
    end
  end

  // Head fields are masked when empty so stale entries never reach the CDB.
  assign cdb_valid = fifo_nonempty;
  assign cdb_data  = fifo_nonempty ? res_mem[rd_ptr_q][DATA_W-1:0] : '0;
  assign cdb_exc   = fifo_nonempty & res_mem[rd_ptr_q][DATA_W];
  assign cdb_rob   = fifo_nonempty ? rob_mem[rd_ptr_q] : '0;
  assign cdb_rd    = fifo_nonempty ? rd_mem[rd_ptr_q] : '0;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Bench for exec_unit_pipe: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_exec_unit_pipe;

  logic       clk1;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] func;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic [2:0] rob_ind;
  logic [3:0] rd;
  logic       flush;
  logic       cdb_grant;
  logic       cdb_valid;
  logic [7:0] cdb_data;
  logic [2:0] cdb_rob;
  logic [3:0] cdb_rd;
  logic       cdb_exc;
  logic       busy;

  exec_unit_pipe dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .rs1_data(rs1_data), .rs2_data(rs2_data), .rob_ind(rob_ind),
    .rd(rd), .flush(flush), .cdb_grant(cdb_grant), .cdb_valid(cdb_valid),
    .cdb_data(cdb_data), .cdb_rob(cdb_rob), .cdb_rd(cdb_rd), .cdb_exc(cdb_exc),
    .busy(busy)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  typedef struct {
    logic [7:0] d;
    logic [2:0] t;
    logic [3:0] r;
    logic       e;
  } ent_t;

  int   n_cmp = 0;
  int   n_bad = 0;

  ent_t mq[$];
  ent_t pend;
  bit   mbusy = 0;
  int   ecount = 0;
  int   done_edge = 0;
  bit   pre_ready = 0;
  bit   m_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_lat(input logic [3:0] f);
    case (f)
      4'd0, 4'd1: return 2;
      4'd2:       return 4;
      4'd3:       return 6;
      default:    return 1;
    endcase
  endfunction

  function automatic ent_t ref_exec(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] t, input logic [3:0] r);
    ent_t x;
    int   ia = int'(a);
    int   ib = int'(b);
    x.t = t;
    x.r = r;
    x.e = 1'b0;
    case (f)
      4'd0: x.d = 8'((ia + ib) % 256);
      4'd1: x.d = 8'((ia - ib + 256) % 256);
      4'd2: x.d = 8'((ia * ib) % 256);
      4'd3: begin
        if (ib == 0) begin
          x.d = 8'hFF;
          x.e = 1'b1;
        end else begin
          x.d = 8'(ia / ib);
        end
      end
      default: begin
        x.d = 8'h00;
        x.e = 1'b1;
      end
    endcase
    return x;
  endfunction

  task automatic model_reset();
    mq.delete();
    mbusy = 0;
  endtask

  // Reference behaviour at one rising edge, using the inputs held across it.
  task automatic model_update();
    bit do_pop;
    bit do_push;
    ecount++;
    m_acc = 0;
    if (flush) begin
      model_reset();
    end else begin
      do_pop  = cdb_grant && (mq.size() > 0);
      do_push = mbusy && (ecount == done_edge);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(pend);
        mbusy = 0;
      end
      if (in_valid && pre_ready) begin
        pend      = ref_exec(func, rs1_data, rs2_data, rob_ind, rd);
        mbusy     = 1;
        done_edge = ecount + ref_lat(func);
        m_acc     = 1;
      end
    end
  endtask

  task automatic check_outputs();
    if (mq.size() > 0) begin
      chk("cdb_valid", 32'(cdb_valid), 32'd1);
      chk("cdb_data", 32'(cdb_data), 32'(mq[0].d));
      chk("cdb_rob", 32'(cdb_rob), 32'(mq[0].t));
      chk("cdb_rd", 32'(cdb_rd), 32'(mq[0].r));
      chk("cdb_exc", 32'(cdb_exc), 32'(mq[0].e));
    end else begin
      chk("cdb_valid", 32'(cdb_valid), 32'd0);
      chk("cdb_idle_fields", 32'({cdb_data, cdb_rob, cdb_rd, cdb_exc}), 32'd0);
    end
    chk("busy", 32'(busy), 32'(mbusy));
  endtask

  // One clock: inputs were set at the preceding falling edge.
  task automatic cycle();
    #1;
    pre_ready = !mbusy && (mq.size() < 2) && !flush;
    chk("in_ready", 32'(in_ready), 32'(pre_ready));
    @(posedge clk1);
    model_update();
    @(negedge clk1);
    check_outputs();
  endtask

  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] t, input logic [3:0] r,
                       input int exp_lat, input logic [7:0] exp_d, input logic exp_e);
    int n;
    bit seen;
    func = f; rs1_data = a; rs2_data = b; rob_ind = t; rd = r;
    in_valid = 1'b1; cdb_grant = 1'b1;
    cycle();
    in_valid = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      cycle();
      n++;
      if (cdb_valid) seen = 1;
    end
    chk("op_latency", 32'(n), 32'(exp_lat));
    chk("op_data", 32'(cdb_data), 32'(exp_d));
    chk("op_exc", 32'(cdb_exc), 32'(exp_e));
    chk("op_rob", 32'(cdb_rob), 32'(t));
    chk("op_rd", 32'(cdb_rd), 32'(r));
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; func = 4'd0; rs1_data = 8'd0; rs2_data = 8'd0;
    rob_ind = 3'd0; rd = 4'd0; flush = 1'b0; cdb_grant = 1'b0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_outputs", 32'({cdb_valid, cdb_data, cdb_rob, cdb_rd, cdb_exc, busy}), 32'd0);
    rst_n = 1'b1;
    model_reset();
    cycle();

    // Single ops with known results and latencies.
    issue(4'd0, 8'h05, 8'h07, 3'd3, 4'd2, 2, 8'h0C, 1'b0);
    issue(4'd2, 8'h10, 8'h11, 3'd4, 4'd5, 4, 8'h10, 1'b0);
    issue(4'd3, 8'h64, 8'h07, 3'd5, 4'd6, 6, 8'h0E, 1'b0);
    issue(4'd3, 8'h09, 8'h00, 3'd6, 4'd7, 6, 8'hFF, 1'b1);
    issue(4'd1, 8'h03, 8'h05, 3'd7, 4'd8, 2, 8'hFE, 1'b0);
    issue(4'b0110, 8'h12, 8'h34, 3'd1, 4'd9, 1, 8'h00, 1'b1);

    // Back-pressure: no grant, three ADDs; only two fit.
    begin
      logic [2:0] t;
      t = 3'd1;
      cdb_grant = 1'b0; func = 4'd0; rob_ind = t; rd = 4'd1; in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
        rs1_data = 8'($urandom); rs2_data = 8'($urandom);
        cycle();
        if (m_acc) begin
          t = t + 3'd1;
          rob_ind = t;
        end
      end
      #1;
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_head_rob", 32'(cdb_rob), 32'd1);
      @(negedge clk1);
      cdb_grant = 1'b1;
      cycle();
      cdb_grant = 1'b0;
      for (int i = 0; i < 6; i++) begin
        cycle();
        if (m_acc) in_valid = 1'b0;
      end
      chk("third_accepted", 32'(in_valid), 32'd0);
      chk("pop1_head_rob", 32'(cdb_rob), 32'd2);
      cdb_grant = 1'b1;
      cycle();
      cdb_grant = 1'b0;
      chk("pop2_head_rob", 32'(cdb_rob), 32'd3);
      cdb_grant = 1'b1;
      cycle();
      cdb_grant = 1'b0;
      chk("drained_valid", 32'(cdb_valid), 32'd0);
    end

    // Flush during a MUL with one result buffered.
    cdb_grant = 1'b0; func = 4'd0; rs1_data = 8'h01; rs2_data = 8'h02; rob_ind = 3'd5; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    func = 4'd2; rs1_data = 8'h03; rob_ind = 3'd6; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("pre_flush_valid", 32'(cdb_valid), 32'd1);
    chk("pre_flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk1);
    repeat (6) cycle();

    // Asynchronous reset in the middle of a DIV.
    cdb_grant = 1'b1; func = 4'd3; rs1_data = 8'hC8; rs2_data = 8'h03; rob_ind = 3'd2; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_outputs", 32'({cdb_valid, cdb_data, cdb_rob, cdb_rd, cdb_exc, busy}), 32'd0);
    model_reset();
    @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (10) cycle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      func      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      rs1_data  = 8'($urandom);
      rs2_data  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rob_ind   = 3'($urandom);
      rd        = 4'($urandom);
      flush     = ($urandom_range(0, 99) < 3);
      cdb_grant = ($urandom_range(0, 99) < 50);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; cdb_grant = 1'b1;
    repeat (12) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
